// File: rtl/qed_consistency_monitor.sv
// QED self-consistency monitor: pairs register j with j+NUM_REGS/2, checks pairs when commit counts match.
// Optional stall timeout is enabled with `define QED_MONITOR_TIMEOUT_EN.
module qed_consistency_monitor #(
    parameter int NUM_REGS    = 32,
    parameter int REG_W       = 72,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 4096,
    localparam int HALF  = NUM_REGS / 2,
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      orig_commit,
    input  logic                      dup_commit,
    input  logic [NUM_REGS*REG_W-1:0] regs_flat,
    output logic                      qed_pass,
    output logic                      qed_error,
    output logic [2:0]                err_code,
    output logic [IDX_W-1:0]          err_idx,
    output logic [CNT_W-1:0]          orig_cnt,
    output logic [CNT_W-1:0]          dup_cnt,
    output logic [CNT_W-1:0]          checks_done
);

    if (NUM_REGS < 2 || NUM_REGS % 2 != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("qed_consistency_monitor: bad parameters");
    end

    typedef enum logic [1:0] {IDLE, RUN, CHECK, ERROR} state_t;

    state_t           state, state_nxt;
    logic [HALF-1:0]  eq_now, eq_vec;
    logic [IDX_W-1:0] first_idx;
    logic [CNT_W:0]   o_next, d_next;
    logic             commit, active, dup_ahead, overflow, mismatch, stall_hit;
    logic             go_check, err_now, pass_nxt, cnt_upd, cnt_clr, dirty;
    logic [2:0]       code_now;

    always_comb begin
        eq_now = '0;
        for (int j = 0; j < HALF; j++)
            eq_now[j] = (regs_flat[j*REG_W +: REG_W] == regs_flat[(j+HALF)*REG_W +: REG_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) eq_vec <= '1;
        else     eq_vec <= eq_now;
    end

    // Scan from the top so the lowest failing pair wins.
    always_comb begin
        first_idx = '0;
        for (int j = HALF - 1; j >= 0; j--)
            if (!eq_vec[j]) first_idx = IDX_W'(j);
    end

    assign commit    = orig_commit | dup_commit;
    assign o_next    = {1'b0, orig_cnt} + {{CNT_W{1'b0}}, orig_commit};
    assign d_next    = {1'b0, dup_cnt} + {{CNT_W{1'b0}}, dup_commit};
    assign active    = (state == RUN && ena) || (state == CHECK);
    assign dup_ahead = d_next > o_next;
    assign overflow  = (orig_commit && (&orig_cnt)) || (dup_commit && (&dup_cnt));
    assign mismatch  = (state == CHECK) && !(&eq_vec);
    assign go_check  = (state == RUN) && ena && !commit && dirty &&
                       (orig_cnt == dup_cnt) && (orig_cnt != '0);

`ifdef QED_MONITOR_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
    logic [ST_W-1:0] stall;

    always_ff @(posedge clk) begin
        if (rst || state != RUN || !ena || orig_cnt == dup_cnt || dup_commit)
            stall <= '0;
        else
            stall <= stall + ST_W'(1);
    end

    assign stall_hit = (state == RUN) && ena && (orig_cnt != dup_cnt) && !dup_commit &&
                       (stall == ST_W'(TIMEOUT_CYC - 1));
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        code_now = 3'd0;
        if (dup_ahead)      code_now = 3'd2;
        else if (overflow)  code_now = 3'd3;
        else if (mismatch)  code_now = 3'd1;
        else if (stall_hit) code_now = 3'd4;
    end

    assign err_now = active && (code_now != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ena) state_nxt = RUN;
            RUN: begin
                if (!ena)         state_nxt = IDLE;
                else if (err_now) state_nxt = ERROR;
                else if (go_check) state_nxt = CHECK;
            end
            CHECK:   state_nxt = err_now ? ERROR : RUN;
            default: state_nxt = ERROR;
        endcase
    end

    always_comb begin
        pass_nxt  = (state == CHECK) && !err_now;
        cnt_upd   = active && !err_now;
        cnt_clr   = (state == IDLE) || (state == RUN && !ena);
        qed_error = (state == ERROR);
    end

    // Counters freeze on the erroring cycle, which also holds them at all-ones on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            qed_pass    <= 1'b0;
            err_code    <= 3'd0;
            err_idx     <= '0;
            orig_cnt    <= '0;
            dup_cnt     <= '0;
            checks_done <= '0;
            dirty       <= 1'b0;
        end else begin
            qed_pass <= pass_nxt;
            if (cnt_clr) begin
                orig_cnt <= '0;
                dup_cnt  <= '0;
                dirty    <= 1'b0;
            end else if (cnt_upd) begin
                orig_cnt <= o_next[CNT_W-1:0];
                dup_cnt  <= d_next[CNT_W-1:0];
                dirty    <= (state == CHECK) ? commit : (dirty | commit);
            end
            if (pass_nxt && !(&checks_done))
                checks_done <= checks_done + CNT_W'(1);
            if (err_now) begin
                err_code <= code_now;
                err_idx  <= (code_now == 3'd1) ? first_idx : '0;
            end
        end
    end

endmodule

// File: tb/tb_qed_consistency_monitor.sv
// Randomized and directed bench for qed_consistency_monitor against a cycle-level reference model.
module tb_qed_consistency_monitor;
    localparam int NR   = 32;
    localparam int RW   = 72;
    localparam int CW   = 4;
    localparam int TO   = 8;
    localparam int H    = NR / 2;
    localparam int IW   = $clog2(H);
    localparam int MAXC = (1 << CW) - 1;
    localparam int OW   = 5 + IW + 3 * CW;
`ifdef QED_MONITOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, ena, orig_commit, dup_commit;
    logic [NR*RW-1:0] regs;
    logic qed_pass, qed_error;
    logic [2:0] err_code;
    logic [IW-1:0] err_idx;
    logic [CW-1:0] orig_cnt, dup_cnt, checks_done;
    logic [OW-1:0] obs;

    int total = 0;
    int bad   = 0;

    qed_consistency_monitor #(.NUM_REGS(NR), .REG_W(RW), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ena(ena), .orig_commit(orig_commit), .dup_commit(dup_commit),
        .regs_flat(regs), .qed_pass(qed_pass), .qed_error(qed_error), .err_code(err_code),
        .err_idx(err_idx), .orig_cnt(orig_cnt), .dup_cnt(dup_cnt), .checks_done(checks_done)
    );

    always #5 clk = ~clk;

    assign obs = {qed_pass, qed_error, err_code, err_idx, orig_cnt, dup_cnt, checks_done};

    // Reference model: plain integers and flags; m_snap is the lowest unequal pair seen last cycle.
    int m_o, m_d, m_done, m_code, m_idx, m_snap, m_stall;
    bit m_run, m_chk, m_err, m_dirty, m_pass;

    function automatic int low_mis(input logic [NR*RW-1:0] r);
        for (int j = 0; j < H; j++)
            if (r[j*RW +: RW] !== r[(j+H)*RW +: RW]) return j;
        return -1;
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        return {m_pass, m_err, 3'(m_code), IW'(m_idx), CW'(m_o), CW'(m_d), CW'(m_done)};
    endfunction

    function automatic logic [NR*RW-1:0] mirrored();
        logic [NR*RW-1:0] r;
        logic [RW-1:0] v;
        r = '0;
        for (int j = 0; j < H; j++) begin
            v = RW'({$urandom, $urandom, $urandom});
            r[j*RW +: RW]     = v;
            r[(j+H)*RW +: RW] = v;
        end
        return r;
    endfunction

    task automatic model_step();
        int no, nd, code, st;
        bit oc, dc, go;
        oc = orig_commit;
        dc = dup_commit;
        if (rst) begin
            m_o = 0; m_d = 0; m_done = 0; m_code = 0; m_idx = 0; m_stall = 0;
            m_run = 0; m_chk = 0; m_err = 0; m_dirty = 0; m_pass = 0; m_snap = -1;
            return;
        end
        m_pass = 0;
        if (m_err) begin
        end else if (!m_run && !m_chk) begin
            m_o = 0; m_d = 0; m_dirty = 0; m_stall = 0;
            if (ena) m_run = 1;
        end else if (m_run && !ena) begin
            m_run = 0; m_o = 0; m_d = 0; m_dirty = 0; m_stall = 0;
        end else begin
            no = m_o + int'(oc);
            nd = m_d + int'(dc);
            go = m_run && !oc && !dc && m_dirty && m_o == m_d && m_o != 0;
            st = (m_run && m_o != m_d && !dc) ? m_stall + 1 : 0;
            m_stall = st;
            code = 0;
            if (nd > no) code = 2;
            else if ((oc && m_o == MAXC) || (dc && m_d == MAXC)) code = 3;
            else if (m_chk && m_snap >= 0) code = 1;
            else if (TO_EN && st == TO) code = 4;
            if (code != 0) begin
                m_err = 1; m_run = 0; m_chk = 0; m_code = code;
                m_idx = (code == 1) ? m_snap : 0;
            end else begin
                m_o = no;
                m_d = nd;
                if (m_chk) begin
                    m_pass = 1;
                    if (m_done < MAXC) m_done++;
                    m_dirty = oc | dc;
                    m_chk = 0; m_run = 1;
                end else begin
                    m_dirty = m_dirty | oc | dc;
                    if (go) begin m_chk = 1; m_run = 0; end
                end
            end
        end
        m_snap = low_mis(regs);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; ena = 0; orig_commit = 0; dup_commit = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic commit_seq();
        ena = 1; tick();
        for (int i = 0; i < 3; i++) begin orig_commit = 1; tick(); end
        orig_commit = 0;
        for (int i = 0; i < 3; i++) begin dup_commit = 1; tick(); end
        dup_commit = 0;
    endtask

    task automatic test_reset();
        regs = mirrored();
        do_reset();
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_pass();
        regs = mirrored();
        do_reset();
        commit_seq();
        total++;
        if ({orig_cnt, dup_cnt} !== {CW'(3), CW'(3)}) begin
            bad++; $display("FAIL pass_counts got=%0d/%0d exp=3/3", orig_cnt, dup_cnt);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (qed_pass !== (k == 2)) begin bad++; $display("FAIL pass_pulse_T+%0d got=%b exp=%b", k, qed_pass, k == 2); end
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL pass_model got=%h exp=%h", obs, exp_vec()); end
        end
        total++;
        if ({qed_error, checks_done} !== {1'b0, CW'(1)}) begin
            bad++; $display("FAIL pass_done got=%b/%0d exp=0/1", qed_error, checks_done);
        end
    endtask

    task automatic test_mismatch();
        regs = mirrored();
        regs[5*RW +: RW]  = '0;
        regs[21*RW +: RW] = RW'(1);
        regs[9*RW +: RW]  = ~regs[25*RW +: RW];
        do_reset();
        commit_seq();
        tick(); tick();
        total++;
        if ({qed_error, err_code, err_idx} !== {1'b1, 3'd1, IW'(5)}) begin
            bad++; $display("FAIL mismatch_err got=%b/%0d/%0d exp=1/1/5", qed_error, err_code, err_idx);
        end
        for (int i = 0; i < 100; i++) begin
            orig_commit = 1'($urandom); dup_commit = 1'($urandom); ena = 1'($urandom);
            tick();
        end
        orig_commit = 0; dup_commit = 0; ena = 1;
        total++;
        if ({qed_error, err_code, err_idx, orig_cnt, dup_cnt} !== {1'b1, 3'd1, IW'(5), CW'(3), CW'(3)}) begin
            bad++; $display("FAIL mismatch_sticky got=%b/%0d/%0d/%0d/%0d exp=1/1/5/3/3",
                            qed_error, err_code, err_idx, orig_cnt, dup_cnt);
        end
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL mismatch_model got=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_dup_ahead();
        regs = mirrored();
        do_reset();
        ena = 1; tick();
        dup_commit = 1; tick(); dup_commit = 0;
        total++;
        if ({qed_error, err_code, dup_cnt} !== {1'b1, 3'd2, CW'(0)}) begin
            bad++; $display("FAIL dup_ahead got=%b/%0d/%0d exp=1/2/0", qed_error, err_code, dup_cnt);
        end
    endtask

    task automatic test_overflow();
        regs = mirrored();
        do_reset();
        ena = 1; tick();
        orig_commit = 1;
        for (int i = 0; i < MAXC; i++) tick();
        total++;
        if ({qed_error, orig_cnt} !== {1'b0, CW'(MAXC)}) begin
            bad++; $display("FAIL overflow_pre got=%b/%0d exp=0/%0d", qed_error, orig_cnt, MAXC);
        end
        tick();
        orig_commit = 0;
        total++;
        if ({qed_error, err_code, orig_cnt} !== {1'b1, 3'd3, CW'(MAXC)}) begin
            bad++; $display("FAIL overflow got=%b/%0d/%0d exp=1/3/%0d", qed_error, err_code, orig_cnt, MAXC);
        end
    endtask

    task automatic test_simul_reset();
        regs = mirrored();
        do_reset();
        ena = 1; tick();
        orig_commit = 1; tick(); tick(); orig_commit = 0;
        dup_commit = 1; tick(); tick();
        orig_commit = 1; tick(); orig_commit = 0; dup_commit = 0;
        total++;
        if ({qed_error, orig_cnt, dup_cnt} !== {1'b0, CW'(3), CW'(3)}) begin
            bad++; $display("FAIL simul_commit got=%b/%0d/%0d exp=0/3/3", qed_error, orig_cnt, dup_cnt);
        end
        tick();
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL simul_model got=%h exp=%h", obs, exp_vec()); end
        rst = 1; ena = 0; tick();
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_mid_check got=%h exp=0", obs); end
        rst = 0; tick();
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_no_pass got=%h exp=0", obs); end
    endtask

    task automatic test_timeout();
        regs = mirrored();
        do_reset();
        ena = 1; tick();
        orig_commit = 1; tick(); orig_commit = 0;
        for (int i = 1; i <= TO + 4; i++) begin
            tick();
            total++;
            if ({qed_error, err_code} !== ((TO_EN && i >= TO) ? 4'b1100 : 4'b0000)) begin
                bad++; $display("FAIL timeout_cyc%0d got=%b/%0d en=%b", i, qed_error, err_code, TO_EN);
            end
        end
    endtask

    task automatic test_random();
        int b;
        for (int ep = 0; ep < 8; ep++) begin
            regs = mirrored();
            do_reset();
            ena = 1;
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 29) == 0) regs = mirrored();
                if ($urandom_range(0, 59) == 0) begin
                    b = int'($urandom_range(H*RW, NR*RW - 1));
                    regs[b] = ~regs[b];
                end
                orig_commit = ($urandom_range(0, 3) == 0);
                dup_commit  = (m_d < m_o) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
                ena = ($urandom_range(0, 99) != 0);
                tick();
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL random_ep%0d_cyc%0d got=%h exp=%h", ep, c, obs, exp_vec());
                end
            end
        end
        orig_commit = 0; dup_commit = 0;
    endtask

    initial begin
        rst = 1; ena = 0; orig_commit = 0; dup_commit = 0; regs = '0;
        test_reset();
        test_pass();
        test_mismatch();
        test_dup_ahead();
        test_overflow();
        test_simul_reset();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qed_consistency_monitor.md
Name: qed_consistency_monitor

Overview:
- Synthesizable, parametrised QED self-consistency monitor for the SPARC core register file.
- Treats the lower half of NUM_REGS registers as the original set and the upper half as the duplicate set; register j pairs with register j+NUM_REGS/2.
- Counts committed original and duplicate instructions. Whenever the two counts are equal and new commits have occurred, it compares every register pair.
- Reports pass pulses, or a sticky error with a cause code and the lowest mismatching register index. Sits beside the decode QED unit and feeds formal covers/asserts and silicon debug.

Parameters:
- NUM_REGS, 32, total integer registers observed; must be even and at least 2.
- REG_W, 72, width of one register including ECC bits.
- CNT_W, 16, width of the commit counters.
- TIMEOUT_CYC, 4096, cycles allowed with unequal counts before a timeout error; used only with the optional feature.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- ena  in  1  monitor enable; while low the FSM holds in IDLE.
- orig_commit  in  1  one original instruction retired this cycle.
- dup_commit  in  1  one duplicate instruction retired this cycle.
- regs_flat  in  NUM_REGS*REG_W  register file; register k is bits [k*REG_W +: REG_W].
- qed_pass  out  1  one-cycle pulse: a check passed.
- qed_error  out  1  sticky error flag.
- err_code  out  3  error cause: 0 none, 1 register mismatch, 2 duplicate ahead, 3 counter overflow, 4 timeout.
- err_idx  out  clog2(NUM_REGS/2)  lowest mismatching pair index j.
- orig_cnt  out  CNT_W  original commit count.
- dup_cnt  out  CNT_W  duplicate commit count.
- checks_done  out  CNT_W  number of passed checks; saturates at all-ones.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; dirty=0; eq_vec is all ones.
- Reset is synchronous and takes priority over everything, including a check in progress and a sticky error.
- eq_vec[j] is registered every cycle as (reg j == reg j+NUM_REGS/2).
- FSM states: IDLE, RUN, CHECK, ERROR.
- IDLE:
  - Counters are held at 0.
  - Moves to RUN on ena=1.
  - Commits arriving in IDLE are ignored.
- RUN:
  - orig_cnt increments on orig_commit; dup_cnt increments on dup_commit. Both may increment in the same cycle.
  - dirty is set on any commit.
  - Move to CHECK in cycle T when all of these hold: no commit in T, dirty=1, orig_cnt==dup_cnt, and orig_cnt!=0.
  - ena=0 in RUN returns the FSM to IDLE and clears the counters and dirty. checks_done is retained.
- CHECK:
  - Evaluates eq_vec, which holds the register snapshot from cycle T. Commits arriving during CHECK still count and set dirty again.
  - All ones: qed_pass=1 in cycle T+2, checks_done increments, dirty clears, and the FSM returns to RUN. Pass latency is 2 cycles.
  - Otherwise: go to ERROR with err_code=1 and err_idx = lowest j where eq_vec[j]=0.
- Error checks in RUN and CHECK, in priority order when several occur in one cycle (lower number wins):
  1. Duplicate ahead: the next dup_cnt would exceed the next orig_cnt -> ERROR, err_code=2.
  2. Counter overflow: an increment of a counter at all-ones -> ERROR, err_code=3; the counter holds at all-ones.
  3. Register mismatch in CHECK.
- ERROR:
  - Sticky; only rst leaves it.
  - qed_error=1; err_code and err_idx are frozen; counters are frozen; qed_pass=0.
- Unless a rule above says otherwise (saturation at all-ones, reset), counters are modulo CNT_W.

Optional Feature:
- Macro: QED_MONITOR_TIMEOUT_EN.
- With the macro: a stall counter runs in RUN while orig_cnt!=dup_cnt.
  - It clears whenever the counts are equal, on any dup_commit, and in IDLE.
  - When it reaches TIMEOUT_CYC -> ERROR with err_code=4.
  - Timeout has the lowest error priority.
- Without the macro: no stall counter exists, and err_code 4 never occurs.

Test Plan:
- Pass check:
  - Stimulus: reset, ena=1; three orig_commit, then three dup_commit; register pairs identical.
  - Response: qed_pass pulses exactly 2 cycles after the first idle cycle with counts 3/3; checks_done=1; qed_error=0.
- Register mismatch:
  - Stimulus: same sequence, but regs 5 and 21 differ (0x0 vs 0x1) and regs 9 and 25 differ.
  - Response: qed_error=1, err_code=1, err_idx=5; error still set 100 cycles later.
- Duplicate ahead:
  - Stimulus: dup_commit with orig_cnt=0.
  - Response: ERROR next cycle, err_code=2, dup_cnt frozen at 0.
- Overflow with CNT_W=4:
  - Stimulus: 16 orig_commit pulses.
  - Response: err_code=3, orig_cnt=15.
- Simultaneous commits and reset mid-check:
  - Stimulus: orig_commit and dup_commit in the same cycle, counts go 2/2 -> 3/3; then rst asserted during CHECK.
  - Response: no error on the simultaneous commits; after rst all outputs are 0, FSM in IDLE, qed_pass not asserted.
- Timeout (QED_MONITOR_TIMEOUT_EN, TIMEOUT_CYC=8):
  - Stimulus: one orig_commit, then idle.
  - Response: err_code=4 after 8 RUN cycles. Built without the macro: no error.
